// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: gathers WIDTH bits MSB- or LSB-first into a word
// and hands each completed word to a single-entry valid/ready holding register.
module shift_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     D_in,
    input  logic                     D_valid,
    input  logic                     LR,
    output logic [WIDTH-1:0]         Y,
    output logic                     Y_valid,
    input  logic                     Y_ready,
    output logic                     busy,
    output logic                     OVF,
    output logic [$clog2(WIDTH):0]   CNT
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] y_q;
    logic             ord_q;
    logic             full_q;
    logic             ovf_q;

    logic             ord_eff;
    logic             last;
    logic [WIDTH-1:0] shifted;

    // The first bit of a word must already use the LR it arrives with.
    assign ord_eff = (state_q == IDLE) ? LR : ord_q;
    assign shifted = ord_eff ? {D_in, s_q[WIDTH-1:1]} : {s_q[WIDTH-2:0], D_in};
    assign last    = D_valid && (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (D_valid) state_d = last ? IDLE : SHIFT;
                SHIFT:   if (last)    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            s_q    <= '0;
            y_q    <= '0;
            ord_q  <= 1'b0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (clear) begin
            cnt_q  <= '0;
            s_q    <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (D_valid) begin
                s_q   <= shifted;
                cnt_q <= last ? '0 : cnt_q + CW'(1);
                if (state_q == IDLE) ord_q <= LR;
            end
            // A drain on the completing edge frees the slot for the new word.
            if (last) begin
                if (!full_q || Y_ready) begin
                    y_q    <= shifted;
                    full_q <= 1'b1;
                end else begin
                    ovf_q  <= 1'b1;
                end
            end else if (full_q && Y_ready) begin
                full_q <= 1'b0;
            end
        end
    end

    assign Y       = y_q;
    assign Y_valid = full_q;
    assign busy    = (state_q == SHIFT);
    assign OVF     = ovf_q;
    assign CNT     = cnt_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: driver pushes expected words, a negedge
// monitor pops and compares them whenever a handshake is presented.
module tb_shift_deserializer;

    logic       clk = 1'b0;
    logic       rst, clear, D_in, D_valid, LR, Y_ready;
    logic [7:0] Y;
    logic       Y_valid, busy, OVF;
    logic [3:0] CNT;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    shift_deserializer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .D_in(D_in), .D_valid(D_valid),
        .LR(LR), .Y(Y), .Y_valid(Y_valid), .Y_ready(Y_ready), .busy(busy),
        .OVF(OVF), .CNT(CNT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Inputs change 2 time units after a rising edge; outputs are sampled there too.
    task automatic drive_bit(input logic d, input logic lr);
        D_valid = 1'b1; D_in = d; LR = lr;
        @(posedge clk); #2;
        D_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
        end
    endtask

    // seq[7] is sent first.
    task automatic send_seq(input logic [7:0] seq, input logic lr);
        for (int i = 7; i >= 0; i--) drive_bit(seq[i], lr);
    endtask

    // Scoreboard monitor: a handshake is presented whenever Y_valid && Y_ready at negedge.
    always @(negedge clk) begin
        if (!rst && Y_valid && Y_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", Y);
            end else begin
                chk("word", Y, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; D_in = 1'b0; D_valid = 1'b0; LR = 1'b0; Y_ready = 1'b1;
        #3;
        chk("rst_Y", Y, 8'h00);
        chk("rst_Y_valid", Y_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_OVF", OVF, 0);
        chk("rst_CNT", CNT, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        idle(1);

        // MSB-first 0xC1 with busy/CNT tracking
        exp_q.push_back(8'hC1);
        for (int i = 7; i >= 0; i--) begin
            drive_bit(8'hC1 >> i, 1'b0);
            if (i > 0) begin
                chk("msb_busy", busy, 1);
                chk("msb_cnt", CNT, 8 - i);
            end
        end
        chk("msb_busy_done", busy, 0);
        chk("msb_cnt_done", CNT, 0);
        chk("msb_valid", Y_valid, 1);
        chk("msb_Y", Y, 8'hC1);
        idle(1);
        chk("msb_drained", Y_valid, 0);

        // LSB-first: bits 1,0,0,0,0,0,1,1 give 0xC1; MSB-case bits give 0x83
        exp_q.push_back(rev(8'h83));
        send_seq(8'h83, 1'b1);
        idle(2);
        exp_q.push_back(rev(8'hC1));
        send_seq(8'hC1, 1'b1);
        idle(2);

        // Order latch: LR flips at bit 3, and a 5-cycle gap follows bit 5
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            drive_bit(8'hA5 >> (7 - i), (i >= 3));
            if (i == 5) begin
                for (int g = 0; g < 5; g++) begin
                    idle(1);
                    chk("gap_cnt", CNT, 6);
                    chk("gap_busy", busy, 1);
                end
            end
        end
        idle(2);

        // Overflow: second word dropped while the first waits
        Y_ready = 1'b0;
        exp_q.push_back(8'h12);
        send_seq(8'h12, 1'b0);
        send_seq(8'h34, 1'b0);
        chk("ovf_Y", Y, 8'h12);
        chk("ovf_valid", Y_valid, 1);
        chk("ovf_flag", OVF, 1);
        Y_ready = 1'b1;
        idle(1);
        Y_ready = 1'b0;
        chk("ovf_drained", Y_valid, 0);
        chk("ovf_sticky", OVF, 1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("ovf_cleared", OVF, 0);

        // Drain and completion on the same edge
        exp_q.push_back(8'h12);
        send_seq(8'h12, 1'b0);
        for (int i = 7; i >= 1; i--) drive_bit(8'h34 >> i, 1'b0);
        exp_q.push_back(8'h34);
        Y_ready = 1'b1;
        drive_bit(1'b0, 1'b0);
        chk("sim_Y", Y, 8'h34);
        chk("sim_valid", Y_valid, 1);
        chk("sim_ovf", OVF, 0);
        idle(2);

        // Asynchronous reset mid-word
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        chk("pre_rst_cnt", CNT, 4);
        #1 rst = 1'b1;
        #1;
        chk("arst_Y", Y, 8'h00);
        chk("arst_valid", Y_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_OVF", OVF, 0);
        chk("arst_CNT", CNT, 0);
        #1 rst = 1'b0;
        @(posedge clk); #2;
        exp_q.push_back(8'h0F);
        send_seq(8'h0F, 1'b0);
        chk("post_rst_Y", Y, 8'h0F);
        idle(2);

        // Synchronous clear mid-word
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_CNT", CNT, 0);
        chk("clr_valid", Y_valid, 0);
        chk("clr_Y_kept", Y, 8'h0F);
        exp_q.push_back(8'h0F);
        send_seq(8'h0F, 1'b0);
        chk("post_clr_Y", Y, 8'h0F);
        idle(3);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
